seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential restoring divider that is the inverse operation of the team's multiply-accumulate datapath.
- Takes an 8-bit dividend, such as a MAC accumulator value, and a 4-bit divisor.
- Produces an 8-bit quotient and a 4-bit remainder, one quotient bit per clock.
- Uses a valid/ready handshake on the input side and on the output side, so it sits downstream of the accumulator register.

Parameters:
- DW, 8, dividend and quotient width; must be at least VW.
- VW, 4, divisor and remainder width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  dividend/divisor presented
- in_ready  output  1  block can accept an operation
- dividend  input  DW  numerator, unsigned
- divisor  input  VW  denominator, unsigned
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- quotient  output  DW  unsigned quotient
- remainder  output  VW  unsigned remainder
- div_by_zero  output  1  result came from divisor==0; qualified by out_valid

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk. All state changes on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Reset asserted at any time, including mid-CALC or in DONE, aborts the operation immediately. There is no partial result and no out_valid pulse.
- FSM states: IDLE, CALC, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE, in_valid=1 and divisor!=0: capture dividend into the quotient shift register, divisor into the divisor register, clear the partial remainder (VW+1 bits), set counter=DW-1, go to CALC.
- IDLE, in_valid=1 and divisor==0: go straight to DONE with quotient=all ones, remainder=0, div_by_zero=1. Latency is 1 edge.
- CALC, one edge per bit:
  - Form t = {R[VW-1:0], Q[DW-1]}.
  - If t >= {0,divisor}: R = t - divisor, new quotient LSB = 1. Otherwise R = t, new quotient LSB = 0.
  - Q shifts left by one.
  - At counter==0, go to DONE. Otherwise decrement the counter.
- Latency: out_valid rises after DW+1 rising edges counting the accept edge, i.e. 9 for DW=8.
- DONE: quotient=Q, remainder=R[VW-1:0], div_by_zero=0 for normal results. Outputs are held stable while out_ready=0.
- DONE with out_ready=1: return to IDLE on that edge. out_valid falls and in_ready rises on the same edge. No new operation is accepted in that same cycle.
- Minimum initiation interval: DW+2 cycles. Operations never overlap.
- in_valid while in_ready=0 is ignored; the source holds its data until in_ready.
- quotient/remainder values while out_valid=0 are working-register contents and are not checked.
- Arithmetic is fully unsigned. remainder < divisor always; quotient*divisor + remainder == dividend.
- Remainder cannot exceed VW bits. The partial remainder uses VW+1 bits internally so the compare never overflows.

Decomposition:
- Shared package div_pkg holds:
  - state encoding constants DIV_IDLE/DIV_CALC/DIV_DONE (2-bit);
  - default widths DIV_DW=8, DIV_VW=4;
  - the divide-by-zero quotient constant (all ones).
- One natural sub-module: div_step, a purely combinational single restoring step.
  - Inputs: R, Q MSB, divisor. Outputs: next R and quotient bit.
  - Instantiated once inside seq_divider's CALC datapath and unit-testable exhaustively.
- FSM, counter and handshake logic stay in seq_divider.

Test Plan:
- Basic division: dividend=200, divisor=7, out_ready=1 -> out_valid exactly 9 edges after accept, quotient=28, remainder=4, div_by_zero=0; in_ready high the cycle after.
- Boundary operands:
  - 255/1 -> quotient=255, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
  - 255/15 -> quotient=17, remainder=0.
  - 0/3 -> quotient=0, remainder=0.
- Divide by zero: dividend=100, divisor=0 -> out_valid after 1 edge, quotient=8'hFF, remainder=0, div_by_zero=1; next op 10/3 -> 3 r1 with div_by_zero=0.
- Output back-pressure: 200/7 with out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
- Reset mid-operation: assert reset 4 edges into CALC -> all outputs at reset values, in_ready=1 immediately; next op 77/6 -> 12 r5.
- Random regression: 1000 random pairs with random out_ready stalls -> quotient*divisor + remainder == dividend and remainder < divisor for every transfer; no lost or duplicated results.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand widths and the divide-by-zero quotient.
package div_pkg;

  localparam int unsigned DIV_DW = 8;
  localparam int unsigned DIV_VW = 4;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_DW-1:0] DIV_DBZ_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// conditionally subtract the divisor and emit one quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned VW = DIV_VW
) (
  input  logic [VW:0]   rem_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   rem_o,
  output logic          q_bit_o
);

  logic [VW+1:0] trial;
  logic [VW+1:0] diff;

  // rem_i is always below the divisor, so its top bit is zero and the
  // shifted trial value fits in VW+1 bits after either branch.
  always_comb begin
    trial   = {rem_i, q_msb_i};
    diff    = trial - (VW+2)'(divisor_i);
    q_bit_o = (trial >= (VW+2)'(divisor_i));
    rem_o   = q_bit_o ? (VW+1)'(diff) : (VW+1)'(trial);
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both the operand and result sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW:0]   rem_q, rem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          dbz_q, dbz_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [VW:0]   step_rem;
  logic          step_bit;

  div_step #(.VW(VW)) u_step (
    .rem_i     (rem_q),
    .q_msb_i   (quot_q[DW-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          if (divisor != '0) begin
            quot_d  = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            dbz_d   = 1'b0;
            cnt_d   = CW'(DW - 1);
            state_d = DIV_CALC;
          end else begin
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = DIV_DONE;
          end
        end
      end
      DIV_CALC: begin
        rem_d  = step_rem;
        quot_d = {quot_q[DW-2:0], step_bit};
        if (cnt_q == '0) begin
          state_d = DIV_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV_DONE: begin
        if (out_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    // Handshake flags are registered copies of the next-state decode.
    in_ready_d  = (state_d == DIV_IDLE);
    out_valid_d = (state_d == DIV_DONE);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q[VW-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic scoreboard model plus
// directed literal checks for latency, boundaries, back-pressure and reset.
module tb_seq_divider;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  logic rnd_mode = 1'b0;
  logic ready_cmd = 1'b1;

  seq_divider dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    else pass_cnt++;
  endtask

  // Sole driver of out_ready: random stalls or the directed command.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end
  end

  // Compare process: every valid cycle matches the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      chk_cnt++;
      if (in_ready && out_valid) $display("FAIL handshake_overlap in_ready=1 out_valid=1");
      else pass_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", 32'd1, 32'd0);
        end else begin
          chk("sb_quotient",  32'(quotient),    32'(exp_q[0].q));
          chk("sb_remainder", 32'(remainder),   32'(exp_q[0].r));
          chk("sb_dbz",       32'(div_by_zero), 32'(exp_q[0].dbz));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present one operation; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [3:0] b);
    int   n;
    logic rdy;
    exp_t e;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) break;
    end
    if (rdy) begin
      if (b == 4'd0) begin
        e.q = 8'hFF; e.r = 4'd0; e.dbz = 1'b1;
      end else begin
        e.q = a / 8'(b); e.r = 4'(a % 8'(b)); e.dbz = 1'b0;
      end
      exp_q.push_back(e);
    end else begin
      chk("send_timeout", 32'd0, 32'd1);
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Total edges from accept to out_valid (accept edge counts as 1).
  task automatic wait_valid(output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (lat > 40) begin
        chk("valid_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic run_directed(input logic [7:0] a, input logic [3:0] b,
                              input logic [7:0] eq, input logic [3:0] er,
                              input logic edbz, input int elat);
    int lat;
    ready_cmd = 1'b1;
    send(a, b);
    wait_valid(lat);
    chk("latency",     32'(lat),         32'(elat));
    chk("quotient",    32'(quotient),    32'(eq));
    chk("remainder",   32'(remainder),   32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(edbz));
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after",  32'(in_ready),  32'd1);
    chk("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("rst_in_ready",  32'(in_ready),    32'd1);
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    chk("rst_quotient",  32'(quotient),    32'd0);
    chk("rst_remainder", 32'(remainder),   32'd0);
    chk("rst_dbz",       32'(div_by_zero), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_directed(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 9);
    run_directed(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9);
    run_directed(8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 9);
    run_directed(8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 9);
    run_directed(8'd0,   4'd3,  8'd0,   4'd0, 1'b0, 9);
    run_directed(8'd100, 4'd0,  8'hFF,  4'd0, 1'b1, 1);
    run_directed(8'd10,  4'd3,  8'd3,   4'd1, 1'b0, 9);

    // Back-pressure: result held, new requests ignored while stalled.
    ready_cmd = 1'b0;
    send(8'd200, 4'd7);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd9);
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      dividend = 8'd50;
      divisor  = 4'd5;
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_quotient",  32'(quotient),  32'd28);
      chk("bp_remainder", 32'(remainder), 32'd4);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    ready_cmd = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready),  32'd1);

    // Reset four edges into CALC aborts with no result.
    send(8'd200, 4'd7);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_in_ready",  32'(in_ready),    32'd1);
    chk("mid_rst_out_valid", 32'(out_valid),   32'd0);
    chk("mid_rst_quotient",  32'(quotient),    32'd0);
    chk("mid_rst_remainder", 32'(remainder),   32'd0);
    chk("mid_rst_dbz",       32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_directed(8'd77, 4'd6, 8'd12, 4'd5, 1'b0, 9);

    // Random regression with random output stalls.
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drained", 32'(exp_q.size()), 32'd0);
    rnd_mode = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
